z80_mcycle_seq: RTL and testbench



---
 rtl/z80_pkg.sv | 30 +++
 rtl/z80_mcycle_decode.sv | 128 ++++++++++++
 rtl/z80_mcycle_seq.sv | 121 ++++++++++++
 tb/tb_z80_mcycle_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/z80_pkg.sv
// Shared Z80 types: M-cycle kinds, T-state encodings, MAR source selects and ALU ops.
package z80_pkg;

  typedef enum logic [1:0] {
    CYC_OCF    = 2'd0,
    CYC_MEM_RD = 2'd1,
    CYC_MEM_WR = 2'd2,
    CYC_RSVD   = 2'd3
  } cyc_type_t;

  typedef enum logic [2:0] {
    TS_IDLE = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_T3   = 3'd3,
    TS_T4   = 3'd4,
    TS_TW   = 3'd5
  } tstate_t;

  typedef enum logic [1:0] {
    SEL_HL = 2'd0,
    SEL_DE = 2'd1,
    SEL_BC = 2'd2,
    SEL_SP = 2'd3
  } addr_sel_t;

  localparam logic [3:0] NOP    = 4'h0;
  localparam logic [3:0] INCR_A = 4'h1;

endpackage

// File: rtl/z80_mcycle_decode.sv
// Combinational map from latched cycle type, pair select and T-state to datapath
// controls and bus strobes. Only ld_IR/ld_MDR1 look at wait_L.
module z80_mcycle_decode
  import z80_pkg::*;
(
  input  cyc_type_t  cyc_type,
  input  addr_sel_t  addr_sel,
  input  tstate_t    t_state,
  input  logic       wait_L,
  output logic       done,
  output logic       M1_L,
  output logic       MREQ_L,
  output logic       RD_L,
  output logic       WR_L,
  output logic       RFSH_L,
  output logic       ld_PCH,
  output logic       ld_PCL,
  output logic       drive_PCH,
  output logic       drive_PCL,
  output logic       drive_B,
  output logic       drive_C,
  output logic       drive_D,
  output logic       drive_E,
  output logic       drive_H,
  output logic       drive_L,
  output logic       drive_SPH,
  output logic       drive_SPL,
  output logic       drive_reg_addr,
  output logic       drive_alu_addr,
  output logic [3:0] alu_op,
  output logic       ld_MARH,
  output logic       ld_MARL,
  output logic       drive_MAR,
  output logic       ld_MDR1,
  output logic       drive_MDR1,
  output logic       ld_IR
);

  always_comb begin
    done           = 1'b0;
    M1_L           = 1'b1;
    MREQ_L         = 1'b1;
    RD_L           = 1'b1;
    WR_L           = 1'b1;
    RFSH_L         = 1'b1;
    ld_PCH         = 1'b0;
    ld_PCL         = 1'b0;
    drive_PCH      = 1'b0;
    drive_PCL      = 1'b0;
    drive_B        = 1'b0;
    drive_C        = 1'b0;
    drive_D        = 1'b0;
    drive_E        = 1'b0;
    drive_H        = 1'b0;
    drive_L        = 1'b0;
    drive_SPH      = 1'b0;
    drive_SPL      = 1'b0;
    drive_reg_addr = 1'b0;
    drive_alu_addr = 1'b0;
    alu_op         = NOP;
    ld_MARH        = 1'b0;
    ld_MARL        = 1'b0;
    drive_MAR      = 1'b0;
    ld_MDR1        = 1'b0;
    drive_MDR1     = 1'b0;
    ld_IR          = 1'b0;

    case (t_state)
      TS_T1: begin
        // Address source goes through the ALU unchanged into MAR.
        drive_reg_addr = 1'b1;
        drive_alu_addr = 1'b1;
        ld_MARH        = 1'b1;
        ld_MARL        = 1'b1;
        if (cyc_type == CYC_OCF) begin
          drive_PCH = 1'b1;
          drive_PCL = 1'b1;
          M1_L      = 1'b0;
        end else begin
          case (addr_sel)
            SEL_HL: begin drive_H   = 1'b1; drive_L   = 1'b1; end
            SEL_DE: begin drive_D   = 1'b1; drive_E   = 1'b1; end
            SEL_BC: begin drive_B   = 1'b1; drive_C   = 1'b1; end
            SEL_SP: begin drive_SPH = 1'b1; drive_SPL = 1'b1; end
            default: ;
          endcase
          drive_MDR1 = (cyc_type == CYC_MEM_WR);
        end
      end
      TS_T2, TS_TW: begin
        drive_MAR = 1'b1;
        MREQ_L    = 1'b0;
        case (cyc_type)
          CYC_OCF:    begin M1_L = 1'b0; RD_L = 1'b0; ld_IR = wait_L; end
          CYC_MEM_RD: begin RD_L = 1'b0; ld_MDR1 = wait_L; end
          CYC_MEM_WR: begin WR_L = 1'b0; drive_MDR1 = 1'b1; end
          default: ;
        endcase
      end
      TS_T3: begin
        if (cyc_type == CYC_OCF) begin
          // PC+1 computed on the address path while refresh runs.
          drive_PCH      = 1'b1;
          drive_PCL      = 1'b1;
          drive_reg_addr = 1'b1;
          drive_alu_addr = 1'b1;
          alu_op         = INCR_A;
          ld_PCH         = 1'b1;
          ld_PCL         = 1'b1;
          RFSH_L         = 1'b0;
        end else begin
          drive_MAR  = 1'b1;
          MREQ_L     = 1'b0;
          RD_L       = (cyc_type != CYC_MEM_RD);
          WR_L       = (cyc_type != CYC_MEM_WR);
          drive_MDR1 = (cyc_type == CYC_MEM_WR);
          done       = 1'b1;
        end
      end
      TS_T4: begin
        RFSH_L = 1'b0;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/z80_mcycle_seq.sv
// M-cycle sequencer: T-state register, cycle acceptance and latching of the
// cycle type / address select; all controls come from z80_mcycle_decode.
module z80_mcycle_seq
  import z80_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cyc_type,
  input  logic [1:0] addr_sel,
  input  logic       wait_L,
  output logic       busy,
  output logic       done,
  output logic [2:0] t_state,
  output logic       M1_L,
  output logic       MREQ_L,
  output logic       RD_L,
  output logic       WR_L,
  output logic       RFSH_L,
  output logic       ld_PCH,
  output logic       ld_PCL,
  output logic       drive_PCH,
  output logic       drive_PCL,
  output logic       drive_B,
  output logic       drive_C,
  output logic       drive_D,
  output logic       drive_E,
  output logic       drive_H,
  output logic       drive_L,
  output logic       drive_SPH,
  output logic       drive_SPL,
  output logic       drive_reg_addr,
  output logic       drive_alu_addr,
  output logic [3:0] alu_op,
  output logic       ld_MARH,
  output logic       ld_MARL,
  output logic       drive_MAR,
  output logic       ld_MDR1,
  output logic       drive_MDR1,
  output logic       ld_IR
);

  tstate_t   state_reg, state_next;
  cyc_type_t type_reg;
  addr_sel_t sel_reg;
  logic      done_int;
  logic      accept;

  // A new cycle may start from IDLE or overlap the final T-state of the current one.
  assign accept = start && (cyc_type != CYC_RSVD) && ((state_reg == TS_IDLE) || done_int);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= TS_IDLE;
      type_reg  <= CYC_OCF;
      sel_reg   <= SEL_HL;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        type_reg <= cyc_type_t'(cyc_type);
        sel_reg  <= addr_sel_t'(addr_sel);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TS_IDLE:      state_next = accept ? TS_T1 : TS_IDLE;
      TS_T1:        state_next = TS_T2;
      TS_T2, TS_TW: state_next = wait_L ? TS_T3 : TS_TW;
      TS_T3: begin
        if (type_reg == CYC_OCF) state_next = TS_T4;
        else                     state_next = accept ? TS_T1 : TS_IDLE;
      end
      TS_T4:        state_next = accept ? TS_T1 : TS_IDLE;
      default:      state_next = TS_IDLE;
    endcase
  end

  always_comb begin
    t_state = state_reg;
    busy    = (state_reg != TS_IDLE);
    done    = done_int;
  end

  z80_mcycle_decode u_decode (
    .cyc_type       (type_reg),
    .addr_sel       (sel_reg),
    .t_state        (state_reg),
    .wait_L         (wait_L),
    .done           (done_int),
    .M1_L           (M1_L),
    .MREQ_L         (MREQ_L),
    .RD_L           (RD_L),
    .WR_L           (WR_L),
    .RFSH_L         (RFSH_L),
    .ld_PCH         (ld_PCH),
    .ld_PCL         (ld_PCL),
    .drive_PCH      (drive_PCH),
    .drive_PCL      (drive_PCL),
    .drive_B        (drive_B),
    .drive_C        (drive_C),
    .drive_D        (drive_D),
    .drive_E        (drive_E),
    .drive_H        (drive_H),
    .drive_L        (drive_L),
    .drive_SPH      (drive_SPH),
    .drive_SPL      (drive_SPL),
    .drive_reg_addr (drive_reg_addr),
    .drive_alu_addr (drive_alu_addr),
    .alu_op         (alu_op),
    .ld_MARH        (ld_MARH),
    .ld_MARL        (ld_MARL),
    .drive_MAR      (drive_MAR),
    .ld_MDR1        (ld_MDR1),
    .drive_MDR1     (drive_MDR1),
    .ld_IR          (ld_IR)
  );

endmodule

// File: tb/tb_z80_mcycle_seq.sv
// Directed per-cycle bench for z80_mcycle_seq: each row gives inputs for one clock
// and the hand-derived state, strobes and control bits expected in that clock.
module tb_z80_mcycle_seq;
  import z80_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, wait_L;
  logic [1:0] cyc_type, addr_sel;
  logic       busy, done;
  logic [2:0] t_state;
  logic       M1_L, MREQ_L, RD_L, WR_L, RFSH_L;
  logic       ld_PCH, ld_PCL, drive_PCH, drive_PCL;
  logic       drive_B, drive_C, drive_D, drive_E, drive_H, drive_L, drive_SPH, drive_SPL;
  logic       drive_reg_addr, drive_alu_addr;
  logic [3:0] alu_op;
  logic       ld_MARH, ld_MARL, drive_MAR, ld_MDR1, drive_MDR1, ld_IR;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  z80_mcycle_seq dut (
    .clk(clk), .rst(rst), .start(start), .cyc_type(cyc_type), .addr_sel(addr_sel),
    .wait_L(wait_L), .busy(busy), .done(done), .t_state(t_state),
    .M1_L(M1_L), .MREQ_L(MREQ_L), .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L),
    .ld_PCH(ld_PCH), .ld_PCL(ld_PCL), .drive_PCH(drive_PCH), .drive_PCL(drive_PCL),
    .drive_B(drive_B), .drive_C(drive_C), .drive_D(drive_D), .drive_E(drive_E),
    .drive_H(drive_H), .drive_L(drive_L), .drive_SPH(drive_SPH), .drive_SPL(drive_SPL),
    .drive_reg_addr(drive_reg_addr), .drive_alu_addr(drive_alu_addr), .alu_op(alu_op),
    .ld_MARH(ld_MARH), .ld_MARL(ld_MARL), .drive_MAR(drive_MAR),
    .ld_MDR1(ld_MDR1), .drive_MDR1(drive_MDR1), .ld_IR(ld_IR)
  );

  // Strobes packed as {M1_L, MREQ_L, RD_L, WR_L, RFSH_L}.
  localparam logic [4:0] S_IDLE = 5'b11111;
  localparam logic [4:0] S_OCF1 = 5'b01111;
  localparam logic [4:0] S_OCF2 = 5'b00011;
  localparam logic [4:0] S_RFSH = 5'b11110;
  localparam logic [4:0] S_RD   = 5'b10011;
  localparam logic [4:0] S_WR   = 5'b10101;

  // Control groups within the packed 20-bit control vector.
  localparam logic [19:0] C_LDPC  = 20'hC0000;
  localparam logic [19:0] C_DRPC  = 20'h30000;
  localparam logic [19:0] C_BC    = 20'h0C000;
  localparam logic [19:0] C_DE    = 20'h03000;
  localparam logic [19:0] C_HL    = 20'h00C00;
  localparam logic [19:0] C_SP    = 20'h00300;
  localparam logic [19:0] C_ADDR  = 20'h000C0;
  localparam logic [19:0] C_LDMAR = 20'h00030;
  localparam logic [19:0] C_DMAR  = 20'h00008;
  localparam logic [19:0] C_LDMDR = 20'h00004;
  localparam logic [19:0] C_DMDR  = 20'h00002;
  localparam logic [19:0] C_LDIR  = 20'h00001;

  logic [4:0]  strb;
  logic [19:0] ctl;
  assign strb = {M1_L, MREQ_L, RD_L, WR_L, RFSH_L};
  assign ctl  = {ld_PCH, ld_PCL, drive_PCH, drive_PCL, drive_B, drive_C, drive_D, drive_E,
                 drive_H, drive_L, drive_SPH, drive_SPL, drive_reg_addr, drive_alu_addr,
                 ld_MARH, ld_MARL, drive_MAR, ld_MDR1, drive_MDR1, ld_IR};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic st,
                     input logic [1:0] ty, input logic [1:0] sl, input logic wl,
                     input logic [2:0] ets, input logic eb, input logic ed,
                     input logic [4:0] es, input logic [19:0] ec, input logic [3:0] ea);
    @(negedge clk);
    rst = r; start = st; cyc_type = ty; addr_sel = sl; wait_L = wl;
    #1;
    $display("cyc %-10s ts=%0d busy=%b done=%b strb=%b ctl=%h alu=%h",
             tag, t_state, busy, done, strb, ctl, alu_op);
    check({tag, ".ts"},   32'(t_state),      32'(ets));
    check({tag, ".bd"},   32'({busy, done}), 32'({eb, ed}));
    check({tag, ".strb"}, 32'(strb),         32'(es));
    check({tag, ".ctl"},  32'(ctl),          32'(ec));
    check({tag, ".alu"},  32'(alu_op),       32'(ea));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cyc_type = 2'd0; addr_sel = 2'd0; wait_L = 1'b1;
    //   tag           rst st ty sl wl  ts b d strobes control                           alu
    cyc("rst",         1, 1, 0, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("idle",        0, 0, 0, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    // Opcode fetch, no waits
    cyc("ocf.req",     0, 1, 0, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("ocf.t1",      0, 0, 0, 0, 1,  1, 1, 0, S_OCF1, C_DRPC|C_ADDR|C_LDMAR,             NOP);
    cyc("ocf.t2",      0, 0, 0, 0, 1,  2, 1, 0, S_OCF2, C_DMAR|C_LDIR,                     NOP);
    cyc("ocf.t3",      0, 0, 0, 0, 1,  3, 1, 0, S_RFSH, C_DRPC|C_ADDR|C_LDPC,              INCR_A);
    cyc("ocf.t4",      0, 0, 0, 0, 1,  4, 1, 1, S_RFSH, 20'h0,                             NOP);
    // Memory read from HL with two waits; type/select changed after acceptance
    cyc("rd.req",      0, 1, 1, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("rd.t1",       0, 0, 2, 3, 1,  1, 1, 0, S_IDLE, C_HL|C_ADDR|C_LDMAR,               NOP);
    cyc("rd.t2",       0, 0, 2, 3, 0,  2, 1, 0, S_RD,   C_DMAR,                            NOP);
    cyc("rd.tw1",      0, 0, 2, 3, 0,  5, 1, 0, S_RD,   C_DMAR,                            NOP);
    cyc("rd.tw2",      0, 0, 2, 3, 1,  5, 1, 0, S_RD,   C_DMAR|C_LDMDR,                    NOP);
    cyc("rd.t3",       0, 0, 2, 3, 1,  3, 1, 1, S_RD,   C_DMAR,                            NOP);
    // Memory write via DE
    cyc("wr.req",      0, 1, 2, 1, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("wr.t1",       0, 0, 0, 0, 1,  1, 1, 0, S_IDLE, C_DE|C_ADDR|C_LDMAR|C_DMDR,        NOP);
    cyc("wr.t2",       0, 0, 0, 0, 1,  2, 1, 0, S_WR,   C_DMAR|C_DMDR,                     NOP);
    cyc("wr.t3",       0, 0, 0, 0, 1,  3, 1, 1, S_WR,   C_DMAR|C_DMDR,                     NOP);
    // Back-to-back: OCF then MEM_RD from SP started during T4
    cyc("b2b.req",     0, 1, 0, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("b2b.o1",      0, 0, 0, 0, 1,  1, 1, 0, S_OCF1, C_DRPC|C_ADDR|C_LDMAR,             NOP);
    cyc("b2b.o2",      0, 0, 0, 0, 1,  2, 1, 0, S_OCF2, C_DMAR|C_LDIR,                     NOP);
    cyc("b2b.o3",      0, 0, 0, 0, 1,  3, 1, 0, S_RFSH, C_DRPC|C_ADDR|C_LDPC,              INCR_A);
    cyc("b2b.o4",      0, 1, 1, 3, 1,  4, 1, 1, S_RFSH, 20'h0,                             NOP);
    cyc("b2b.r1",      0, 0, 0, 0, 1,  1, 1, 0, S_IDLE, C_SP|C_ADDR|C_LDMAR,               NOP);
    cyc("b2b.r2",      0, 0, 0, 0, 1,  2, 1, 0, S_RD,   C_DMAR|C_LDMDR,                    NOP);
    cyc("b2b.r3",      0, 0, 0, 0, 1,  3, 1, 1, S_RD,   C_DMAR,                            NOP);
    // Reserved type is ignored; start during T2 is ignored
    cyc("rsv.req",     0, 1, 3, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("ign.req",     0, 1, 1, 2, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("ign.t1",      0, 0, 0, 0, 1,  1, 1, 0, S_IDLE, C_BC|C_ADDR|C_LDMAR,               NOP);
    cyc("ign.t2",      0, 1, 0, 0, 1,  2, 1, 0, S_RD,   C_DMAR|C_LDMDR,                    NOP);
    cyc("ign.t3",      0, 0, 0, 0, 1,  3, 1, 1, S_RD,   C_DMAR,                            NOP);
    // Reset in the middle of a wait state discards the cycle
    cyc("rr.req",      0, 1, 1, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("rr.t1",       0, 0, 0, 0, 1,  1, 1, 0, S_IDLE, C_HL|C_ADDR|C_LDMAR,               NOP);
    cyc("rr.t2",       0, 0, 0, 0, 0,  2, 1, 0, S_RD,   C_DMAR,                            NOP);
    cyc("rr.tw",       0, 0, 0, 0, 0,  5, 1, 0, S_RD,   C_DMAR,                            NOP);
    cyc("rr.rst",      1, 0, 0, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("rr.after",    0, 0, 0, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    cyc("rr.idle",     0, 0, 0, 0, 1,  0, 0, 0, S_IDLE, 20'h0,                             NOP);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
